// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver that packs incoming bytes little-endian into 32-bit words
// and writes each completed word to a word-addressed data memory.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        loadEn,
  output logic        memWriteEn,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  output logic [31:0] wordCount,
  output logic        busy,
  output logic        frameError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT         state;
  logic          rxMeta;
  logic          rxS;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic [1:0]    byteIdx;
  logic [31:0]   wordBuf;
  logic [31:0]   nextWord;
  logic [31:0]   wordAddr;
  logic          writeQ;
  logic          loadEnQ;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the two stages really are two clock cycles apart.
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  always_comb begin
    // NOTE: assigning the default first keeps this purely combinational;
    // a path that skipped the assignment would infer a latch.
    nextWord = wordBuf;
    nextWord[{byteIdx, 3'b000} +: 8] = shiftReg;
  end

  // A write is suppressed in the cycle loadEn drops, so no strobe leaks out.
  assign memWriteEn = writeQ & loadEn;
  assign wordCount  = wordAddr;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      byteIdx    <= '0;
      wordBuf    <= '0;
      wordAddr   <= '0;
      writeQ     <= 1'b0;
      loadEnQ    <= 1'b0;
      memAddress <= '0;
      memDataIn  <= '0;
      frameError <= 1'b0;
    end else begin
      writeQ  <= 1'b0;
      loadEnQ <= loadEn;
      if (memWriteEn) wordAddr <= wordAddr + 32'd1;
      if (loadEn && !loadEnQ) frameError <= 1'b0;

      if (!loadEn) begin
        state    <= IDLE;
        cnt      <= '0;
        bitIdx   <= '0;
        byteIdx  <= '0;
        wordAddr <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!rxS) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_HALF) begin
              cnt    <= '0;
              bitIdx <= '0;
              state  <= rxS ? IDLE : DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == CNT_FULL) begin
              cnt              <= '0;
              shiftReg[bitIdx] <= rxS;
              bitIdx           <= bitIdx + 3'd1;
              if (bitIdx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              state <= IDLE;
              if (rxS) begin
                wordBuf <= nextWord;
                byteIdx <= byteIdx + 2'd1;
                if (byteIdx == 2'd3) begin
                  writeQ     <= 1'b1;
                  memDataIn  <= nextWord;
                  memAddress <= wordAddr;
                end
              end else begin
                // Bad stop bit: drop this byte and the partial word with it.
                frameError <= 1'b1;
                byteIdx    <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
